// File: rtl/ga23_gfx_cache.sv
// Direct-mapped read cache for the graphics SDRAM port, with optional next-word prefetch.
// Single outstanding fetch. A read that arrives during a prefetch is held in a one-deep pending slot.
module ga23_gfx_cache #(
  parameter int unsigned ENTRIES  = 4,
  parameter int unsigned PREFETCH = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [21:0] rd_addr,
  input  logic        rd_req,
  output logic [31:0] rd_data,
  output logic        rd_rdy,
  output logic        busy,
  input  logic        flush,
  output logic [21:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data,
  input  logic        mem_rdy
);
  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 20 - IW;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_PF} state_t;

  state_t             r_state, w_state_nxt;
  logic [ENTRIES-1:0] r_valid;
  logic [TW-1:0]      r_tag  [ENTRIES];
  logic [31:0]        r_data [ENTRIES];
  logic [19:0]        r_fetch_waddr, r_pend_waddr;
  logic               r_pend, r_nofill, r_rd_rdy, r_mem_req;
  logic [31:0]        r_rd_data;
  logic [21:0]        r_mem_addr;

  logic [19:0]   w_lk_waddr, w_pf_waddr;
  logic [IW-1:0] w_lk_idx, w_pf_idx, w_fill_idx;
  logic          w_lk_req, w_lk_hit, w_pf_res, w_install;
  logic          w_lookup, w_hit, w_miss, w_ret, w_pf_go, w_fill;

  // A pending read always takes priority over a fresh strobe in IDLE.
  assign w_lk_req   = r_pend | rd_req;
  assign w_lk_waddr = r_pend ? r_pend_waddr : rd_addr[21:2];
  assign w_lk_idx   = w_lk_waddr[IW-1:0];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_waddr[19:IW]) && !flush;
  assign w_pf_waddr = r_fetch_waddr + 20'd1;
  assign w_pf_idx   = w_pf_waddr[IW-1:0];
  assign w_pf_res   = r_valid[w_pf_idx] && (r_tag[w_pf_idx] == w_pf_waddr[19:IW]) && !flush;
  assign w_fill_idx = r_fetch_waddr[IW-1:0];
  assign w_install  = w_fill && !r_nofill && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lookup    = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_ret       = 1'b0;
    w_pf_go     = 1'b0;
    w_fill      = 1'b0;
    busy        = (r_state == S_MISS);
    unique case (r_state)
      S_IDLE: begin
        if (w_lk_req) begin
          w_lookup = 1'b1;
          if (w_lk_hit) begin
            w_hit = 1'b1;
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (mem_rdy) begin
          w_fill = 1'b1;
          w_ret  = 1'b1;
          if ((PREFETCH != 0) && !w_pf_res) begin
            w_pf_go     = 1'b1;
            w_state_nxt = S_PF;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_PF: begin
        if (mem_rdy) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid       <= '0;
      r_pend        <= 1'b0;
      r_pend_waddr  <= '0;
      r_fetch_waddr <= '0;
      r_nofill      <= 1'b0;
      r_rd_rdy      <= 1'b0;
      r_rd_data     <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else begin
      r_rd_rdy  <= 1'b0;
      r_mem_req <= 1'b0;
      if (w_lookup) begin
        r_pend <= r_pend & rd_req;
        if (rd_req) r_pend_waddr <= rd_addr[21:2];
      end else if ((r_state == S_PF) && rd_req && !r_pend) begin
        r_pend       <= 1'b1;
        r_pend_waddr <= rd_addr[21:2];
      end
      if (w_hit) begin
        r_rd_rdy  <= 1'b1;
        r_rd_data <= r_data[w_lk_idx];
      end
      if (w_miss) begin
        r_mem_req     <= 1'b1;
        r_mem_addr    <= {w_lk_waddr, 2'b00};
        r_fetch_waddr <= w_lk_waddr;
        r_nofill      <= 1'b0;
      end
      if (w_ret) begin
        r_rd_rdy  <= 1'b1;
        r_rd_data <= mem_data;
      end
      if (w_pf_go) begin
        r_mem_req     <= 1'b1;
        r_mem_addr    <= {w_pf_waddr, 2'b00};
        r_fetch_waddr <= w_pf_waddr;
        r_nofill      <= 1'b0;
      end
      // A flush during an outstanding fetch marks that fetch as not installable.
      if (flush && (r_state != S_IDLE)) r_nofill <= 1'b1;
      if (flush)          r_valid             <= '0;
      else if (w_install) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tag[w_fill_idx]  <= r_fetch_waddr[19:IW];
      r_data[w_fill_idx] <= mem_data;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_rdy   = r_rd_rdy;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
endmodule

// File: tb/tb_ga23_gfx_cache.sv
// Self-checking bench for ga23_gfx_cache: the model is a set of per-index resident word addresses
// plus a word-addressed memory image; randomized reads and fetch latencies.
module tb_ga23_gfx_cache;
  localparam int unsigned ENTRIES  = 4;
  localparam int unsigned PREFETCH = 1;

  logic        clk = 1'b0;
  logic        reset_n, rd_req, flush, mem_rdy;
  logic [21:0] rd_addr;
  logic [31:0] rd_data, mem_data;
  logic        rd_rdy, busy, mem_req;
  logic [21:0] mem_addr;

  int nchecks = 0;
  int nerrors = 0;

  bit          mval [ENTRIES];
  logic [19:0] mword[ENTRIES];
  logic [31:0] memv [logic [19:0]];

  ga23_gfx_cache #(.ENTRIES(ENTRIES), .PREFETCH(PREFETCH)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_req(rd_req),
    .rd_data(rd_data), .rd_rdy(rd_rdy), .busy(busy), .flush(flush),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] getmem(input logic [19:0] w);
    if (memv.exists(w)) return memv[w];
    return {w[11:0], w} ^ 32'hA5C3_0F17;
  endfunction

  function automatic bit resident(input logic [19:0] w);
    return mval[w % ENTRIES] && (mword[w % ENTRIES] == w);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) mval[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [19:0] w);
    mval[w % ENTRIES]  = 1'b1;
    mword[w % ENTRIES] = w;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    model_clear();
  endtask

  // One complete read including any demand fetch and prefetch.
  task automatic do_read(input logic [21:0] a, input bit fl_with, input bit fl_during);
    logic [19:0] w, pw;
    bit hit, pf;
    int d;
    w = a[21:2];
    if (fl_with) model_clear();
    hit = resident(w);
    @(negedge clk); rd_req = 1'b1; rd_addr = a; flush = fl_with;
    @(negedge clk); rd_req = 1'b0; flush = 1'b0;
    nchecks++; if (rd_rdy !== hit) begin nerrors++; $display("FAIL hit_rdy a=%h: got %b exp %b", a, rd_rdy, hit); end
    nchecks++; if (mem_req !== !hit) begin nerrors++; $display("FAIL miss_req a=%h: got %b exp %b", a, mem_req, !hit); end
    if (hit) begin
      nchecks++; if (rd_data !== getmem(w)) begin nerrors++; $display("FAIL hit_data a=%h: got %h exp %h", a, rd_data, getmem(w)); end
      return;
    end
    nchecks++; if (mem_addr !== {w, 2'b00}) begin nerrors++; $display("FAIL miss_addr: got %h exp %h", mem_addr, {w, 2'b00}); end
    nchecks++; if (busy !== 1'b1) begin nerrors++; $display("FAIL busy_miss: got %b exp 1", busy); end
    d = $urandom_range(0, 3);
    if (fl_during && d == 0) d = 1;
    for (int i = 0; i < d; i++) begin
      if (fl_during && i == 0) flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      nchecks++; if (mem_req !== 1'b0 || rd_rdy !== 1'b0) begin nerrors++; $display("FAIL miss_wait: req %b rdy %b exp 0 0", mem_req, rd_rdy); end
    end
    if (fl_during) model_clear();
    mem_rdy = 1'b1; mem_data = getmem(w);
    @(negedge clk); mem_rdy = 1'b0;
    nchecks++; if (rd_rdy !== 1'b1 || rd_data !== getmem(w)) begin nerrors++; $display("FAIL fill_ret a=%h: got %b/%h exp 1/%h", a, rd_rdy, rd_data, getmem(w)); end
    nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL busy_done: got %b exp 0", busy); end
    if (!fl_during) model_fill(w);
    pw = w + 20'd1;
    pf = (PREFETCH != 0) && !resident(pw);
    nchecks++; if (mem_req !== pf) begin nerrors++; $display("FAIL pf_req a=%h: got %b exp %b", a, mem_req, pf); end
    if (!pf) return;
    nchecks++; if (mem_addr !== {pw, 2'b00}) begin nerrors++; $display("FAIL pf_addr: got %h exp %h", mem_addr, {pw, 2'b00}); end
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      nchecks++; if (mem_req !== 1'b0 || rd_rdy !== 1'b0 || busy !== 1'b0) begin nerrors++; $display("FAIL pf_wait: req %b rdy %b busy %b exp 0 0 0", mem_req, rd_rdy, busy); end
    end
    mem_rdy = 1'b1; mem_data = getmem(pw);
    @(negedge clk); mem_rdy = 1'b0;
    nchecks++; if (rd_rdy !== 1'b0) begin nerrors++; $display("FAIL pf_no_rdy: got %b exp 0", rd_rdy); end
    model_fill(pw);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++; if ({rd_rdy, mem_req, busy} !== 3'b000) begin nerrors++; $display("FAIL reset_ctl: got %b exp 000", {rd_rdy, mem_req, busy}); end
    nchecks++; if (rd_data !== 32'h0 || mem_addr !== 22'h0) begin nerrors++; $display("FAIL reset_data: got %h/%h exp 0/0", rd_data, mem_addr); end
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_miss_and_prefetch_hit();
    memv[20'h00041] = 32'hDEADBEEF;
    do_read(22'h000104, 1'b0, 1'b0);
    do_read(22'h00010B, 1'b0, 1'b0);
  endtask

  task automatic test_conflict();
    do_read(22'h000000, 1'b0, 1'b0);
    do_read(22'h000010, 1'b0, 1'b0);
    do_read(22'h000000, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    pulse_flush();
    do_read(22'h3FFFFC, 1'b0, 1'b0);
    do_read(22'h000001, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    do_read(22'h000120, 1'b0, 1'b1);
    do_read(22'h000120, 1'b0, 1'b0);
    do_read(22'h000120, 1'b1, 1'b0);
  endtask

  task automatic test_pf_pending();
    pulse_flush();
    @(negedge clk); rd_req = 1'b1; rd_addr = 22'h000200;
    @(negedge clk); rd_req = 1'b0;
    mem_rdy = 1'b1; mem_data = getmem(20'h00080);
    @(negedge clk); mem_rdy = 1'b0;
    model_fill(20'h00080);
    nchecks++; if (mem_req !== 1'b1 || mem_addr !== 22'h000204) begin nerrors++; $display("FAIL pend_pf: got %b/%h exp 1/000204", mem_req, mem_addr); end
    rd_req = 1'b1; rd_addr = 22'h000206; mem_rdy = 1'b1; mem_data = getmem(20'h00081);
    @(negedge clk); rd_req = 1'b0; mem_rdy = 1'b0;
    model_fill(20'h00081);
    nchecks++; if (rd_rdy !== 1'b0 || mem_req !== 1'b0) begin nerrors++; $display("FAIL pend_early: rdy %b req %b exp 0 0", rd_rdy, mem_req); end
    @(negedge clk);
    nchecks++; if (rd_rdy !== 1'b1 || rd_data !== getmem(20'h00081) || mem_req !== 1'b0) begin nerrors++; $display("FAIL pend_resp: got %b/%h/%b exp 1/%h/0", rd_rdy, rd_data, mem_req, getmem(20'h00081)); end
    @(negedge clk);
    nchecks++; if (rd_rdy !== 1'b0) begin nerrors++; $display("FAIL pend_once: got %b exp 0", rd_rdy); end
  endtask

  task automatic test_busy_ignore_and_stray();
    pulse_flush();
    @(negedge clk); rd_req = 1'b1; rd_addr = 22'h000300;
    @(negedge clk); rd_req = 1'b1; rd_addr = 22'h000400;
    @(negedge clk); rd_req = 1'b0;
    nchecks++; if (rd_rdy !== 1'b0 || mem_req !== 1'b0) begin nerrors++; $display("FAIL busy_ignore: rdy %b req %b exp 0 0", rd_rdy, mem_req); end
    mem_rdy = 1'b1; mem_data = getmem(20'h000C0);
    @(negedge clk); mem_rdy = 1'b0;
    nchecks++; if (rd_rdy !== 1'b1 || rd_data !== getmem(20'h000C0)) begin nerrors++; $display("FAIL busy_ret: got %b/%h exp 1/%h", rd_rdy, rd_data, getmem(20'h000C0)); end
    mem_rdy = 1'b1; mem_data = getmem(20'h000C1);
    @(negedge clk); mem_rdy = 1'b0;
    model_fill(20'h000C0); model_fill(20'h000C1);
    @(negedge clk);
    nchecks++; if (rd_rdy !== 1'b0 || mem_req !== 1'b0) begin nerrors++; $display("FAIL busy_late: rdy %b req %b exp 0 0", rd_rdy, mem_req); end
    mem_rdy = 1'b1; mem_data = 32'h1234_5678;
    @(negedge clk); mem_rdy = 1'b0;
    @(negedge clk);
    nchecks++; if (rd_rdy !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin nerrors++; $display("FAIL stray_idle: rdy %b req %b busy %b exp 0 0 0", rd_rdy, mem_req, busy); end
    do_read(22'h000300, 1'b0, 1'b0);
    do_read(22'h000400, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    pulse_flush();
    @(negedge clk); rd_req = 1'b1; rd_addr = 22'h000500;
    @(negedge clk); rd_req = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    model_clear();
    nchecks++; if ({rd_rdy, mem_req, busy} !== 3'b000) begin nerrors++; $display("FAIL rst_mid: got %b exp 000", {rd_rdy, mem_req, busy}); end
    mem_rdy = 1'b1; mem_data = 32'hCAFE_F00D;
    @(negedge clk); mem_rdy = 1'b0;
    nchecks++; if (rd_rdy !== 1'b0 || mem_req !== 1'b0) begin nerrors++; $display("FAIL rst_stray: rdy %b req %b exp 0 0", rd_rdy, mem_req); end
    do_read(22'h000500, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [21:0] a;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) a = 22'h3FFFE0 + 22'($urandom_range(0, 31));
      else                           a = 22'($urandom_range(0, 127));
      do_read(a, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    rd_req = 1'b0; rd_addr = '0; flush = 1'b0; mem_rdy = 1'b0; mem_data = '0;
    test_reset();
    test_cold_miss_and_prefetch_hit();
    test_conflict();
    test_wrap();
    test_flush();
    test_pf_pending();
    test_busy_ignore_and_stray();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/ga23_gfx_cache.md
GA23_GFX_CACHE -- requirements
Module: ga23_gfx_cache

Interface
REQ-001 Parameter ENTRIES, default 4, number of direct-mapped 32-bit word entries; power of two, 2..16.
REQ-002 Parameter PREFETCH, default 1, enables next-word prefetch after a miss (0 = disabled).
REQ-003 clk  input  1  sole clock; all logic rises on posedge clk.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 rd_addr  input  22  client byte address, sampled when rd_req=1.
REQ-006 rd_req  input  1  client read strobe, one-cycle pulse.
REQ-007 rd_data  output  32  read data, valid when rd_rdy=1.
REQ-008 rd_rdy  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high while a client miss is outstanding; client must not pulse rd_req while busy=1.
REQ-010 flush  input  1  one-cycle pulse that invalidates all entries.
REQ-011 mem_addr  output  22  word-aligned fetch address to the graphics SDRAM arbiter port.
REQ-012 mem_req  output  1  one-cycle fetch pulse; at most one fetch outstanding.
REQ-013 mem_data  input  32  fetch data, valid with mem_rdy.
REQ-014 mem_rdy  input  1  one-cycle fetch completion pulse.

Function
REQ-015 Address split: bits [1:0] ignored; index = next log2(ENTRIES) bits above bit 1; tag = remaining upper bits; each entry holds a valid bit, tag, and data.
REQ-016 mem_addr[1:0] shall always be 0.
REQ-017 States: IDLE, MISS (client fetch outstanding), PF (prefetch outstanding).
REQ-018 IDLE, rd_req at cycle T, hit: rd_data = entry data, rd_rdy=1 at T+1; state stays IDLE.
REQ-019 IDLE, rd_req at T, miss: mem_req=1 and mem_addr = {rd_addr[21:2],2'b00} at T+1; state MISS; busy=1 from T+1.
REQ-020 MISS, mem_rdy at cycle M: install entry (valid=1); rd_data = mem_data and rd_rdy=1 at M+1; busy=0 at M+1.
REQ-021 At M+1, if PREFETCH=1 and word (miss address + 4) is not resident, issue mem_req for it; state PF. Otherwise, state IDLE.
REQ-022 The prefetch address wraps modulo 2^22 (0x3FFFFC + 4 = 0x000000).
REQ-023 PF, mem_rdy: install prefetched entry; state IDLE next cycle; prefetch never produces rd_rdy.
REQ-024 rd_req during PF (busy=0) is captured into a one-deep pending register and looked up in the cycle after PF exits, with the same latency rules as REQ-018/019 counted from that cycle.
REQ-025 rd_req and mem_rdy in the same PF cycle: fill installs first; the pending lookup sees the new entry.
REQ-026 rd_req while busy=1 is a protocol violation: ignored, no response.
REQ-027 flush clears all valid bits at the next edge.
REQ-028 flush coincident with an IDLE rd_req: that lookup is a miss.
REQ-029 flush while MISS or PF: the outstanding fill still returns client data (MISS) but is not installed.
REQ-030 mem_rdy in IDLE is ignored.
REQ-031 rd_rdy and mem_req shall never be high for more than one consecutive cycle per transaction.

Reset
REQ-032 reset_n=0: state IDLE; all valid bits 0; pending cleared; rd_rdy=0, mem_req=0, busy=0, rd_data=0, mem_addr=0.
REQ-033 Reset mid-MISS/PF abandons the fetch; a later stray mem_rdy is ignored per REQ-030.

Verification
REQ-034 Cold miss: rd_addr=0x000104 at T -> mem_req/mem_addr=0x000104 at T+1; mem_rdy with 0xDEADBEEF at M -> rd_rdy, rd_data=0xDEADBEEF at M+1; prefetch mem_addr=0x000108 at M+1.
REQ-035 Prefetch hit: after REQ-034 completes, rd_addr=0x00010B -> rd_rdy at T+1, prefetched data, no mem_req.
REQ-036 Conflict eviction (ENTRIES=4): read 0x000000, then 0x000010 (same index) -> second is a miss; rereading 0x000000 misses again.
REQ-037 Wrap: miss at 0x3FFFFC -> prefetch mem_addr=0x000000.
REQ-038 Flush during MISS: data returned to client; immediate reread of the same address issues a new mem_req.
REQ-039 rd_req during PF to the prefetch address, with mem_rdy in the same cycle -> rd_rdy one cycle after PF exits, no extra mem_req.
